// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU control unit and the ALU execute stage:
// the 4-bit ALU control codes and the execute-stage FSM state type.
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'b1100;
  localparam logic [ALU_CTRL_W-1:0] ALU_MUL = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alu_state_t;

endpackage : alu_pkg

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter
// Iterative shift-add multiplier producing the low WIDTH bits of the unsigned
// product, one multiplier bit per cycle.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start_i    load operands, clear accumulator and counter
//   run_i      perform one iteration this cycle (owner FSM is BUSY)
//   a_i, b_i   multiplicand / multiplier, sampled on start_i
//   done_o     this cycle's iteration is the last one
//   product_o  accumulator value after this cycle's iteration; equals the
//              final product when done_o is high
// ---------------------------------------------------------------------------
module alu_mul_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             run_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] product_o
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q,    acc_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] acc_next;

  // Product bits above WIDTH are never needed, so the accumulator and the
  // left-shifting multiplicand simply wrap at WIDTH bits.
  assign acc_next  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign product_o = acc_next;
  assign done_o    = run_i && (cnt_q == LAST_CNT);

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (run_i) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule : alu_mul_iter

// File: rtl/alu_exec_stage.sv
// ---------------------------------------------------------------------------
// alu_exec_stage
// Execute stage fed by the ALU control unit. Single-cycle ops are computed
// combinationally and registered (latency 1); MUL runs on alu_mul_iter and
// presents its result WIDTH cycles after accept. Valid/ready on both sides.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  upstream handshake
//   alu_ctrl             4-bit ALU control code
//   op_a, op_b           operands
//   out_valid/out_ready  downstream handshake
//   result, zero         registered result and result==0 flag
//   overflow             signed ADD/SUB overflow, registered with result
//                        (present only when ALU_OVF_EN is defined)
//
// Build option: ALU_OVF_EN adds the overflow port and its logic.
// ---------------------------------------------------------------------------
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ALU_CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]      op_a,
  input  logic [WIDTH-1:0]      op_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      result,
  output logic                  zero
`ifdef ALU_OVF_EN
  ,
  output logic                  overflow
`endif
);

  // Unknown codes fall through to 0 (and therefore zero=1).
  function automatic logic [WIDTH-1:0] alu_single(
    input logic [ALU_CTRL_W-1:0] ctrl,
    input logic [WIDTH-1:0]      a,
    input logic [WIDTH-1:0]      b
  );
    logic [WIDTH-1:0] r;
    r = '0;
    case (ctrl)
      ALU_AND: r = a & b;
      ALU_OR:  r = a | b;
      ALU_ADD: r = a + b;
      ALU_SUB: r = a - b;
      ALU_SLT: r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_NOR: r = ~(a | b);
      default: r = '0;
    endcase
    return r;
  endfunction

`ifdef ALU_OVF_EN
  function automatic logic signed_ovf(
    input logic [ALU_CTRL_W-1:0] ctrl,
    input logic [WIDTH-1:0]      a,
    input logic [WIDTH-1:0]      b,
    input logic [WIDTH-1:0]      r
  );
    logic o;
    o = 1'b0;
    case (ctrl)
      ALU_ADD: o = (a[WIDTH-1] == b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      ALU_SUB: o = (a[WIDTH-1] != b[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
      default: o = 1'b0;
    endcase
    return o;
  endfunction
`endif

  alu_state_t       state_q,     state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q,    result_d;
  logic             zero_q,      zero_d;
`ifdef ALU_OVF_EN
  logic             ovf_q,       ovf_d;
`endif

  logic             accept;
  logic             is_mul;
  logic [WIDTH-1:0] single_res;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;

  // A new op may enter in the same cycle the pending result drains.
  assign in_ready   = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept     = in_valid && in_ready;
  assign is_mul     = (alu_ctrl == ALU_MUL);
  assign single_res = alu_single(alu_ctrl, op_a, op_b);

  alu_mul_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (accept && is_mul),
    .run_i     (state_q == BUSY),
    .a_i       (op_a),
    .b_i       (op_b),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    zero_d      = zero_q;
`ifdef ALU_OVF_EN
    ovf_d       = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            // out_valid is already heading to 0 (in_ready guaranteed it),
            // so the multiply can never overwrite an unconsumed result.
            state_d = BUSY;
          end else begin
            result_d    = single_res;
            zero_d      = (single_res == '0);
            out_valid_d = 1'b1;
`ifdef ALU_OVF_EN
            ovf_d       = signed_ovf(alu_ctrl, op_a, op_b, single_res);
`endif
          end
        end
      end
      BUSY: begin
        // The last iteration lands straight in the result register.
        if (mul_done) begin
          result_d    = mul_product;
          zero_d      = (mul_product == '0);
          out_valid_d = 1'b1;
          state_d     = IDLE;
`ifdef ALU_OVF_EN
          ovf_d       = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
`ifdef ALU_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
`ifdef ALU_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign zero      = zero_q;
`ifdef ALU_OVF_EN
  assign overflow  = ovf_q;
`endif

endmodule : alu_exec_stage

// File: tb/tb_alu_exec_stage.sv
module tb_alu_exec_stage;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
`ifdef ALU_OVF_EN
  logic         overflow;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_exec_stage #(
    .WIDTH (W),
    .CNT_W (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero)
`ifdef ALU_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  // Reference: the op table written as plain arithmetic.
  function automatic logic [W-1:0] model_res(input logic [3:0] c,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint unsigned pa, pb, p;
    longint sa, sb;
    pa = a; pb = b; sa = $signed(a); sb = $signed(b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return W'(pa + pb);
      4'b0110: return W'(pa - pb);
      4'b0111: return (sa < sb) ? 1 : 0;
      4'b1100: return ~(a | b);
      4'b1000: begin p = pa * pb; return W'(p); end
      default: return '0;
    endcase
  endfunction

`ifdef ALU_OVF_EN
  function automatic logic model_ovf(input logic [3:0] c,
                                     input logic [W-1:0] a,
                                     input logic [W-1:0] b);
    longint sa, sb, s;
    sa = $signed(a); sb = $signed(b);
    if (c == 4'b0010)      s = sa + sb;
    else if (c == 4'b0110) s = sa - sb;
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction
`endif

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    alu_ctrl = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (result !== '0) begin n_err++; $display("FAIL reset_result got %h want 0", result); end
    n_cmp++; if (zero !== 1'b0) begin n_err++; $display("FAIL reset_zero got %b want 0", zero); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
`ifdef ALU_OVF_EN
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow); end
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [3:0]   c [6] = '{4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0000, 4'b1111};
    logic [W-1:0] a [6] = '{32'd5, 32'd3, 32'hFFFFFFFF, 32'd0, 32'hF0F0F0F0, 32'hFFFFFFFF};
    logic [W-1:0] b [6] = '{32'd7, 32'd3, 32'd1, 32'd0, 32'h0FF00FF0, 32'hFFFFFFFF};
    logic [W-1:0] e [6] = '{32'd12, 32'd0, 32'd1, 32'hFFFFFFFF, 32'h00F000F0, 32'd0};
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; alu_ctrl = c[i]; op_a = a[i]; op_b = b[i];
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL dir_in_ready[%0d] got %b want 1", i, in_ready); end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL dir_out_valid[%0d] got %b want 1", i, out_valid); end
      n_cmp++; if (result !== e[i]) begin n_err++; $display("FAIL dir_result[%0d] got %h want %h", i, result, e[i]); end
      n_cmp++; if (zero !== (e[i] == '0)) begin n_err++; $display("FAIL dir_zero[%0d] got %b want %b", i, zero, (e[i] == '0)); end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL dir_drain got %b want 0", out_valid); end
  endtask

  task automatic test_random_single();
    logic [3:0]   c;
    logic [W-1:0] a, b, e;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      c = 4'($urandom_range(0, 15));
      if (c == 4'b1000) c = 4'b0010;
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      e = model_res(c, a, b);
      in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || result !== e || zero !== (e == '0)) begin
        n_err++;
        $display("FAIL rnd[%0d] ctrl=%b a=%h b=%h got v=%b r=%h z=%b want v=1 r=%h z=%b",
                 i, c, a, b, out_valid, result, zero, e, (e == '0));
      end
`ifdef ALU_OVF_EN
      n_cmp++; if (overflow !== model_ovf(c, a, b)) begin n_err++; $display("FAIL rnd_ovf[%0d] got %b want %b", i, overflow, model_ovf(c, a, b)); end
`endif
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [W-1:0] a [6];
    logic [W-1:0] b [6];
    logic [W-1:0] e;
    logic early, busy_ready;
    a[0] = 32'd6;       b[0] = 32'd7;
    a[1] = 32'h10000;   b[1] = 32'h10000;
    a[2] = 32'hFFFFFFFF; b[2] = 32'hFFFFFFFF;
    for (int i = 3; i < 6; i++) begin a[i] = $urandom; b[i] = $urandom; end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      e = model_res(4'b1000, a[i], b[i]);
      in_valid = 1'b1; alu_ctrl = 4'b1000; op_a = a[i]; op_b = b[i];
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL mul_accept_ready[%0d] got %b want 1", i, in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0; op_a = $urandom; op_b = $urandom;
      early = out_valid; busy_ready = in_ready;
      for (int k = 1; k < W; k++) begin
        @(posedge clk); #1;
        if (out_valid) early = 1'b1;
        if (in_ready) busy_ready = 1'b1;
      end
      n_cmp++; if (early !== 1'b0) begin n_err++; $display("FAIL mul_early_valid[%0d] got %b want 0", i, early); end
      n_cmp++; if (busy_ready !== 1'b0) begin n_err++; $display("FAIL mul_busy_in_ready[%0d] got %b want 0", i, busy_ready); end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mul_valid[%0d] got %b want 1", i, out_valid); end
      n_cmp++; if (result !== e || zero !== (e == '0)) begin
        n_err++; $display("FAIL mul_result[%0d] a=%h b=%h got %h z=%b want %h z=%b", i, a[i], b[i], result, zero, e, (e == '0));
      end
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mul_drain[%0d] got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_backpressure();
    logic held;
    out_ready = 1'b0;
    in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd1; op_b = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0; op_a = 32'd100; op_b = 32'd200;
    held = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      n_cmp++; if (out_valid !== 1'b1 || result !== 32'd2 || in_ready !== 1'b0) begin
        n_err++; $display("FAIL bp_hold[%0d] got v=%b r=%h rdy=%b want v=1 r=2 rdy=0", k, out_valid, result, in_ready);
      end
    end
    in_valid = 1'b1; op_a = 32'd2; op_b = 32'd2; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_on_drain got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'd4) begin
      n_err++; $display("FAIL bp_back_to_back got v=%b r=%h want v=1 r=4", out_valid, result);
    end
    @(posedge clk); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_final_drain got %b want 0", out_valid); end
  endtask

  task automatic test_reset_mid_mul();
    logic seen;
    out_ready = 1'b1;
    in_valid = 1'b1; alu_ctrl = 4'b1000; op_a = 32'd6; op_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmul_valid got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmul_in_ready got %b want 1", in_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmul_stale got %b want 0", seen); end
    n_cmp++; if (in_ready !== 1'b1 || result !== '0) begin
      n_err++; $display("FAIL rstmul_idle got rdy=%b r=%h want rdy=1 r=0", in_ready, result);
    end
    in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd9; op_b = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1 || result !== 32'd10) begin
      n_err++; $display("FAIL rstmul_after got v=%b r=%h want v=1 r=10", out_valid, result);
    end
    @(posedge clk); #1;
  endtask

`ifdef ALU_OVF_EN
  task automatic test_overflow();
    logic [3:0]   c [3] = '{4'b0010, 4'b0110, 4'b0000};
    logic [W-1:0] a [3] = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [W-1:0] b [3] = '{32'd1, 32'd1, 32'hFFFFFFFF};
    logic [W-1:0] e [3] = '{32'h80000000, 32'h7FFFFFFF, 32'hFFFFFFFF};
    logic         o [3] = '{1'b1, 1'b1, 1'b0};
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; alu_ctrl = c[i]; op_a = a[i]; op_b = b[i];
      @(posedge clk); #1;
      n_cmp++; if (result !== e[i] || overflow !== o[i]) begin
        n_err++; $display("FAIL ovf[%0d] got r=%h o=%b want r=%h o=%b", i, result, overflow, e[i], o[i]);
      end
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random_single();
    test_mul();
    test_backpressure();
    test_reset_mid_mul();
`ifdef ALU_OVF_EN
    test_overflow();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_alu_exec_stage
